ext_mem_responder: RTL and testbench

Word-addressed external-memory responder that serves the memory side of the inverted residual block's external-memory interface (request_extmem, write_extmem, addr_extmem, w_data in; valid_extmem, data_extmem out). It accepts one read or write per cycle with no backpressure, commits writes immediately, and returns read data in order after a fixed pipeline latency. It is used as the external DRAM model in the block-level bench and as the memory-side endpoint in FPGA bring-up.

---
 rtl/ext_mem_responder.sv | 89 ++++++++
 tb/tb_ext_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_responder.sv
// Word-addressed external-memory responder: single-cycle accept, immediate write commit,
// in-order reads returned through a LAT-deep valid/data shift pipeline.
module ext_mem_responder #(
    parameter int unsigned DEPTH    = 65536,
    parameter int unsigned LAT      = 2,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request_extmem,
    input  logic        write_extmem,
    input  logic [31:0] addr_extmem,
    input  logic [31:0] w_data,
    output logic        valid_extmem,
    output logic [31:0] data_extmem,
    output logic        err_extmem,
    output logic        busy,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic          oor;
        logic [AW-1:0] idx;
        logic [31:0]   wdata;
    } req_t;

    req_t req;
    logic [31:0] mem [DEPTH];

    logic [LAT-1:0]       vld_pipe;
    logic [LAT-1:0][31:0] dat_pipe;
    logic                 err_q;
    logic [31:0]          rd_cnt_q;
    logic [31:0]          wr_cnt_q;
    logic                 mem_we;

    // Acceptance is gated by rst so requests during reset neither write nor count.
    always_comb begin
        req.rd    = rst & request_extmem & ~write_extmem;
        req.wr    = rst & request_extmem &  write_extmem;
        req.oor   = ({1'b0, addr_extmem} >= 33'(DEPTH));
        req.idx   = addr_extmem[AW-1:0];
        req.wdata = w_data;
        mem_we    = req.wr & ~req.oor;
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[req.idx] <= req.wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            vld_pipe[0] <= req.rd;
            if (req.rd)
                dat_pipe[0] <= req.oor ? ERR_DATA : mem[req.idx];
            // Data stages only move with a valid token, so the output holds between pulses.
            for (int i = 1; i < int'(LAT); i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    dat_pipe[i] <= dat_pipe[i-1];
            end
            if (req.rd)
                rd_cnt_q <= rd_cnt_q + 32'd1;
            if (req.wr)
                wr_cnt_q <= wr_cnt_q + 32'd1;
            if ((req.rd | req.wr) & req.oor)
                err_q <= 1'b1;
        end
    end

    assign valid_extmem = vld_pipe[LAT-1];
    assign data_extmem  = dat_pipe[LAT-1];
    assign err_extmem   = err_q;
    assign busy         = (|vld_pipe) | req.rd;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;
endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: LAT=2 and LAT=1 instances share stimulus and are checked
// against a transaction-level model (associative memory plus a queue of accepted reads).
module tb_ext_mem_responder;
    localparam int unsigned DEPTH = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        request_extmem = 1'b0;
    logic        write_extmem = 1'b0;
    logic [31:0] addr_extmem = '0;
    logic [31:0] w_data = '0;

    logic        v2, e2, b2, v1, e1, b1;
    logic [31:0] d2, rc2, wc2, d1, rc1, wc1;

    ext_mem_responder #(.DEPTH(DEPTH), .LAT(2), .ERR_DATA(32'h0)) u2 (
        .clk(clk), .rst(rst), .request_extmem(request_extmem), .write_extmem(write_extmem),
        .addr_extmem(addr_extmem), .w_data(w_data), .valid_extmem(v2), .data_extmem(d2),
        .err_extmem(e2), .busy(b2), .rd_count(rc2), .wr_count(wc2));

    ext_mem_responder #(.DEPTH(DEPTH), .LAT(1), .ERR_DATA(32'h0)) u1 (
        .clk(clk), .rst(rst), .request_extmem(request_extmem), .write_extmem(write_extmem),
        .addr_extmem(addr_extmem), .w_data(w_data), .valid_extmem(v1), .data_extmem(d1),
        .err_extmem(e1), .busy(b1), .rd_count(rc1), .wr_count(wc1));

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [31:0] d;
    } rd_t;

    rd_t         rq[$];
    logic [31:0] mmem [int unsigned];
    int          h1 = 0, h2 = 0;
    int          e = 0;
    logic [31:0] m_rd = 0, m_wr = 0;
    logic        m_err = 0;
    int          tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input int lat, input int hin, output int hout,
                           input logic cur_rd, input logic in_rst,
                           input logic v, input logic [31:0] d, input logic b,
                           input logic er, input logic [31:0] rc, input logic [31:0] wc);
        logic exp_v;
        exp_v = (hin < rq.size()) && (rq[hin].t + lat - 1 == e);
        chk({nm, ".valid"}, {31'b0, v}, {31'b0, exp_v});
        if (exp_v) chk({nm, ".data"}, d, rq[hin].d);
        if (in_rst) chk({nm, ".rst_data"}, d, 32'h0);
        chk({nm, ".busy"}, {31'b0, b}, {31'b0, (hin < rq.size()) | cur_rd});
        chk({nm, ".err"}, {31'b0, er}, {31'b0, m_err});
        chk({nm, ".rd_count"}, rc, m_rd);
        chk({nm, ".wr_count"}, wc, m_wr);
        hout = exp_v ? hin + 1 : hin;
    endtask

    // mode 0: normal cycle; 1: rst low across the whole cycle; 2: rst low for a partial cycle
    task automatic tick(input int mode, input bit rq_, input bit wr_,
                        input logic [31:0] a, input logic [31:0] dd);
        int nh;
        @(negedge clk);
        rst = (mode == 0);
        request_extmem = rq_;
        write_extmem = wr_;
        addr_extmem = a;
        w_data = dd;
        if (mode != 0) begin
            h1 = rq.size(); h2 = rq.size();
            m_rd = 0; m_wr = 0; m_err = 0;
        end
        #1;
        chk_dut("lat2", 2, h2, nh, rst & rq_ & ~wr_, mode != 0, v2, d2, b2, e2, rc2, wc2); h2 = nh;
        chk_dut("lat1", 1, h1, nh, rst & rq_ & ~wr_, mode != 0, v1, d1, b1, e1, rc1, wc1); h1 = nh;
        if (mode == 2) begin
            #2 rst = 1'b1;
        end
        @(posedge clk);
        e++;
        if (rst && rq_) begin
            if (a >= DEPTH) m_err = 1'b1;
            if (wr_) begin
                m_wr++;
                if (a < DEPTH) mmem[a] = dd;
            end else begin
                m_rd++;
                rq.push_back('{t: e, d: (a < DEPTH) ? mmem[a] : 32'h0});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);

        // write then read-after-write on the next edge
        tick(0, 1, 1, 5, 32'hCAFE_0001);
        tick(0, 1, 0, 5, 0);
        idle(3);

        // preload and burst-read 0..7
        for (int i = 0; i < 8; i++) tick(0, 1, 1, i, 100 + i);
        for (int i = 0; i < 8; i++) tick(0, 1, 0, i, 0);
        idle(4);

        // out-of-range read, then dropped out-of-range write aliasing to 65535
        tick(0, 1, 1, 65535, 32'h5A5A_0000);
        tick(0, 1, 0, DEPTH, 0);
        idle(2);
        tick(0, 1, 1, 32'hFFFF_FFFF, 32'h0000_1234);
        tick(0, 1, 0, 65535, 0);
        idle(3);

        // reset pulse with reads in flight
        tick(0, 1, 0, 0, 0);
        tick(0, 1, 0, 1, 0);
        tick(0, 1, 0, 2, 0);
        tick(2, 0, 0, 0, 0);
        idle(3);
        tick(0, 1, 0, 5, 0);
        idle(3);

        // write request held during reset is ignored
        tick(1, 1, 1, 5, 32'hDEAD_BEEF);
        tick(0, 1, 0, 5, 0);
        idle(3);

        // alternating write/read to one address
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, 9, 1000 + i);
            tick(0, 1, 0, 9, 0);
        end
        idle(3);

        // write counter wrap
        #1;
        force u2.wr_cnt_q = 32'hFFFF_FFFE;
        force u1.wr_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u2.wr_cnt_q;
        release u1.wr_cnt_q;
        m_wr = 32'hFFFF_FFFE;
        tick(0, 1, 1, 20, 32'h20);
        tick(0, 1, 1, 21, 32'h21);
        tick(0, 1, 1, 22, 32'h22);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 31);
            if (r <= 2) tick(0, 0, 0, 0, 0);
            else if (r <= 5) tick(0, 1, 1, a, $urandom);
            else if (r <= 8) begin
                if (mmem.exists(a)) tick(0, 1, 0, a, 0);
                else tick(0, 1, 1, a, $urandom);
            end else begin
                a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : DEPTH + $urandom_range(0, 1000);
                tick(0, 1, $urandom_range(0, 1) == 1, a, $urandom);
            end
        end
        idle(4);

        chk("lat2.drained", h2, rq.size());
        chk("lat1.drained", h1, rq.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
